uart_frame_rx: RTL and testbench

Oversampling UART frame receiver: the decoding end of the serial frame format the UART transmit path and its stimulus produce. The frame is a start bit (0), 8 data bits MSB first, an even-parity bit, and a stop bit (1). The block recovers the data byte from the asynchronous `rx` line. It presents the byte on a valid/ready interface with parity, framing and overrun status. It sits between the pad-side `rx` pin and the Rx FIFO write port.

---
 rtl/uart_frame_rx.sv | 215 +++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits MSB first, even parity, stop.
// The byte is presented on a valid/ready port with parity, framing and overrun status.
module uart_frame_rx #(
    parameter int OVERSAMBLE = 16,
    parameter int CLK_FREQ   = 10_000_000,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            SelBaudRate,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int DIV_RAW_0 = CLK_FREQ / (4800 * OVERSAMBLE);
    localparam int DIV_RAW_1 = CLK_FREQ / (9600 * OVERSAMBLE);
    localparam int DIV_RAW_2 = CLK_FREQ / (57600 * OVERSAMBLE);
    localparam int DIV_RAW_3 = CLK_FREQ / (115200 * OVERSAMBLE);
    localparam int DIV_0 = (DIV_RAW_0 < 1) ? 1 : DIV_RAW_0;
    localparam int DIV_1 = (DIV_RAW_1 < 1) ? 1 : DIV_RAW_1;
    localparam int DIV_2 = (DIV_RAW_2 < 1) ? 1 : DIV_RAW_2;
    localparam int DIV_3 = (DIV_RAW_3 < 1) ? 1 : DIV_RAW_3;

    localparam int TW = $clog2(OVERSAMBLE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMBLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMBLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, rxs_q;
    logic [1:0]            sel_q, sel_d;
    logic [31:0]           div_cnt_q, div_cnt_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic [31:0]           div_last;
    logic                  tick;
    logic                  frame_done;

    always_comb begin
        case (sel_q)
            2'b00:   div_last = 32'(DIV_0 - 1);
            2'b01:   div_last = 32'(DIV_1 - 1);
            2'b10:   div_last = 32'(DIV_2 - 1);
            default: div_last = 32'(DIV_3 - 1);
        endcase
    end

    assign tick = (div_cnt_q == div_last);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        div_cnt_d    = div_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        frame_done   = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (state_q != S_IDLE) begin
            div_cnt_d = tick ? 32'd0 : div_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d    = S_START;
                    sel_d      = SelBaudRate;
                    div_cnt_d  = 32'd0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    perr_d     = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shreg_d    = {shreg_q[DATA_WIDTH-2:0], rxs_q};
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_PARITY;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        perr_d     = (rxs_q != ^shreg_q);
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        frame_done = 1'b1;
                        state_d    = rxs_q ? S_IDLE : S_BREAK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must go high again before a new start is accepted.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                parity_err_d = perr_q;
                frame_err_d  = !rxs_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            sel_q        <= 2'b00;
            div_cnt_q    <= 32'd0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= rx;
            rxs_q        <= sync1_q;
            sel_q        <= sel_d;
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: serial frames are driven bit by bit and the received
// bytes, status flags, latency and overrun pulses are compared with a frame-level model.
module tb_uart_frame_rx;

    localparam int OS       = 16;
    localparam int CLK_FREQ = 10_000_000;
    localparam int DW       = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    sel;
    logic          rx;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    uart_frame_rx #(
        .OVERSAMBLE(OS),
        .CLK_FREQ  (CLK_FREQ),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SelBaudRate(sel),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int ov_rise_cyc = 0;
    int vr_count = 0;
    int ov_count = 0;
    int ov_hi    = 0;
    logic prev_valid = 1'b0;
    logic prev_ov    = 1'b0;

    // Entries are {frame_err, parity_err, data}.
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            got_q.push_back({frame_err, parity_err, rx_data});
        end
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            vr_count <= vr_count + 1;
            rise_cyc <= cyc;
        end
        prev_valid <= rx_valid;
        if (overrun === 1'b1) ov_hi <= ov_hi + 1;
        if (overrun === 1'b1 && prev_ov !== 1'b1) begin
            ov_count    <= ov_count + 1;
            ov_rise_cyc <= cyc;
        end
        prev_ov <= overrun;
    end

    function automatic int div_of(input logic [1:0] s);
        int baud;
        int d;
        case (s)
            2'b00:   baud = 4800;
            2'b01:   baud = 9600;
            2'b10:   baud = 57600;
            default: baud = 115200;
        endcase
        d = CLK_FREQ / (baud * OS);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int lat_of(input logic [1:0] s);
        return 2 + div_of(s) * (OS / 2 + (DW + 2) * OS) + 1;
    endfunction

    function automatic logic [DW+1:0] model(input logic [DW-1:0] d, input logic p, input logic s);
        return {~s, p ^ (^d), d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input logic [1:0] rate);
        int n;
        n = OS * div_of(rate);
        sel = rate;
        rx = 1'b0;
        fall_cyc = cyc;
        wait_clks(n);
        // The rate is latched at the start edge, so changing it now must not matter.
        sel = 2'($urandom_range(0, 3));
        for (int i = DW - 1; i >= 0; i--) begin
            rx = d[i];
            wait_clks(n);
        end
        rx = p;
        wait_clks(n);
        rx = s;
        wait_clks(n);
    endtask

    task automatic compare_frames();
        logic [DW+1:0] e;
        logic [31:0]   g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) g = 32'(got_q.pop_front());
            else g = 32'hDEAD;
            chk("frame", g, 32'(e));
        end
        chk("extra_frames", got_q.size(), 0);
        got_q.delete();
    endtask

    initial begin
        int n3;
        int vr0;
        int ov0;
        int oh0;
        logic [DW-1:0] d;
        logic          p;
        logic [1:0]    s;

        n3 = OS * div_of(2'b11);
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        sel = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clks(2);

        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        // Single frame, held until accepted.
        send_frame(8'hA5, 1'b0, 1'b1, 2'b11);
        exp_q.push_back(model(8'hA5, 1'b0, 1'b1));
        wait_clks(2 * n3);
        chk("single_latency", rise_cyc - fall_cyc, lat_of(2'b11));
        chk("single_valid", rx_valid, 1);
        chk("single_data", rx_data, 8'hA5);
        chk("single_perr", parity_err, 0);
        chk("single_ferr", frame_err, 0);
        wait_clks(3 * n3);
        chk("single_hold_valid", rx_valid, 1);
        chk("single_hold_data", rx_data, 8'hA5);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        chk("single_accept_clears", rx_valid, 0);
        compare_frames();

        // Back-to-back frames, a parity error first, then random frames.
        rx_ready = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1, 2'b11);
        exp_q.push_back(model(8'h01, 1'b0, 1'b1));
        send_frame(8'h3C, 1'b0, 1'b1, 2'b11);
        exp_q.push_back(model(8'h3C, 1'b0, 1'b1));
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(2, 3));
            exp_q.push_back(model(d, p, 1'b1));
            send_frame(d, p, 1'b1, s);
        end
        wait_clks(2 * OS * div_of(2'b10));
        compare_frames();

        // Framing error followed by a break.
        vr0 = vr_count;
        send_frame(8'hFF, 1'b0, 1'b0, 2'b11);
        exp_q.push_back(model(8'hFF, 1'b0, 1'b0));
        wait_clks(3 * n3);
        chk("break_busy", busy, 1);
        rx = 1'b1;
        wait_clks(2 * n3);
        chk("break_idle", busy, 0);
        chk("break_one_frame", vr_count - vr0, 1);
        compare_frames();

        // Short low glitch must not start a frame.
        vr0 = vr_count;
        sel = 2'b11;
        rx = 1'b0;
        wait_clks(3 * div_of(2'b11));
        rx = 1'b1;
        chk("glitch_busy_seen", busy, 1);
        wait_clks(n3);
        chk("glitch_idle", busy, 0);
        chk("glitch_no_frame", vr_count - vr0, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 2'b11);
        exp_q.push_back(model(8'h5A, 1'b0, 1'b1));
        wait_clks(2 * n3);
        chk("glitch_next_frame", vr_count - vr0, 1);
        compare_frames();

        // Overrun: second frame is dropped while the first is still held.
        rx_ready = 1'b0;
        ov0 = ov_count;
        oh0 = ov_hi;
        send_frame(8'h11, 1'b0, 1'b1, 2'b11);
        exp_q.push_back(model(8'h11, 1'b0, 1'b1));
        send_frame(8'h22, 1'b0, 1'b1, 2'b11);
        wait_clks(2 * n3);
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_pulses", ov_count - ov0, 1);
        chk("ovr_width", ov_hi - oh0, 1);
        chk("ovr_timing", ov_rise_cyc - fall_cyc, lat_of(2'b11));
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        chk("ovr_accept_clears", rx_valid, 0);
        compare_frames();

        // Reset in the middle of the data bits.
        vr0 = vr_count;
        d = 8'hB7;
        sel = 2'b11;
        rx = 1'b0;
        wait_clks(n3);
        for (int i = DW - 1; i > DW - 5; i--) begin
            rx = d[i];
            wait_clks(n3);
        end
        rx = d[DW-5];
        wait_clks(n3 / 2);
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        rx = 1'b1;
        wait_clks(2 * n3);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_parity_err", parity_err, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_no_frame", vr_count - vr0, 0);

        send_frame(8'hC3, 1'b0, 1'b1, 2'b00);
        exp_q.push_back(model(8'hC3, 1'b0, 1'b1));
        wait_clks(OS * div_of(2'b00));
        chk("slow_latency", rise_cyc - fall_cyc, lat_of(2'b00));
        chk("slow_valid", rx_valid, 1);
        chk("slow_data", rx_data, 8'hC3);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        compare_frames();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
